// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard, stall/flush and operand-forwarding controller for the
//             5-stage pipe. A 3-state FSM holds the pipe while a multi-cycle
//             (MUL/DIV) op is in flight, guarded by a sticky watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MAX_MC_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic       RegWE,
  input  logic       MemtoRegE,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWM,
  input  logic       RegWW,
  input  logic       PCSrcE,
  input  logic       MStartE,
  input  logic       MDone,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic [1:0] mc_state,
  output logic       mc_timeout
);

  // State encoding doubles as the externally visible mc_state value.
  localparam logic [1:0] MC_IDLE = 2'b00;
  localparam logic [1:0] MC_BUSY = 2'b01;
  localparam logic [1:0] MC_DONE = 2'b10;

  // Forwarding mux select encoding.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // R15 is the PC; it is never forwarded from a later stage.
  localparam logic [3:0] PC_REG = 4'd15;

  // Counter only has to reach MAX_MC_CYCLES-1.
  localparam int         CNT_W    = (MAX_MC_CYCLES > 2) ? $clog2(MAX_MC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MC_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             r_timeout;
  logic             w_busy;
  logic             w_ldstall;
  logic             w_watchdog_hit;

  // Pick the youngest producer of a source register; Memory beats Writeback.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       we_m,
    input logic [3:0] dst_m,
    input logic       we_w,
    input logic [3:0] dst_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (dst_m == src) && (dst_m != PC_REG)) begin
      sel = FWD_MEM;
    end else if (we_w && (dst_w == src) && (dst_w != PC_REG)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Operand forwarding selects for the Execute stage.
  always_comb begin
    ForwardAE = fwd_sel(RA1E, RegWM, WA3M, RegWW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWM, WA3M, RegWW, WA3W);
  end

  // Load-use hazard: a load in E produces a register that D wants to read.
  always_comb begin
    w_ldstall = MemtoRegE && RegWE && ((WA3E == RA1D) || (WA3E == RA2D));
  end

  // Watchdog fires on the last permitted busy cycle when no result arrived.
  always_comb begin
    w_watchdog_hit = (r_state == MC_BUSY) && !MDone && (r_count == CNT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MC_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; MStartE is ignored in MC_DONE so the op cannot retrigger.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MC_IDLE: begin
        if (MStartE) begin
          w_next_state = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (MDone || w_watchdog_hit) begin
          w_next_state = MC_DONE;
        end
      end
      MC_DONE: begin
        w_next_state = MC_IDLE;
      end
      default: begin
        w_next_state = MC_IDLE;
      end
    endcase
  end

  // Busy-cycle counter: cleared on op start, advances every busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_state == MC_IDLE) begin
      if (MStartE) begin
        r_count <= '0;
      end
    end else if (r_state == MC_BUSY) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_watchdog_hit) begin
      r_timeout <= 1'b1;
    end
  end

  // FSM output logic: a busy pipe stalls everything and masks branch/load-use.
  always_comb begin
    w_busy = (r_state == MC_BUSY) || ((r_state == MC_IDLE) && MStartE);
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (w_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      // A taken branch discards the younger instructions, so it overrides the stall.
      StallF = w_ldstall && !PCSrcE;
      StallD = w_ldstall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = PCSrcE || w_ldstall;
    end
  end

  // Status outputs.
  always_comb begin
    mc_state   = r_state;
    mc_timeout = r_timeout;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             plus randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
  localparam int MAXC = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0, WA3E = '0, WA3M = '0, WA3W = '0;
  logic RegWE = 0, MemtoRegE = 0, RegWM = 0, RegWW = 0, PCSrcE = 0, MStartE = 0, MDone = 0;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_timeout;
  logic [1:0] ForwardAE, ForwardBE, mc_state;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  pipe_hazard_ctrl #(.MAX_MC_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RegWE(RegWE), .MemtoRegE(MemtoRegE), .WA3M(WA3M), .WA3W(WA3W),
    .RegWM(RegWM), .RegWW(RegWW), .PCSrcE(PCSrcE), .MStartE(MStartE), .MDone(MDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mc_state(mc_state), .mc_timeout(mc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age: -1 when no op in flight, otherwise the number of busy cycles already elapsed.
  int m_age = -1;
  bit m_done = 0;
  bit m_tmo = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= -1;
      m_done <= 0;
      m_tmo  <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_age >= 0) begin
      if (MDone || m_age == MAXC - 1) begin
        m_age  <= -1;
        m_done <= 1;
        if (!MDone) m_tmo <= 1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (MStartE) begin
      m_age <= 0;
    end
  end

  function automatic logic [1:0] exp_fwd(input logic [3:0] src);
    if (RegWM && WA3M == src && WA3M != 4'd15) return 2'b10;
    if (RegWW && WA3W == src && WA3W != 4'd15) return 2'b01;
    return 2'b00;
  endfunction

  // Compare process: every negedge the DUT must agree with the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic busy, ld;
      logic [1:0] st;
      st   = m_done ? 2'b10 : (m_age >= 0 ? 2'b01 : 2'b00);
      busy = (m_age >= 0) || (!m_done && MStartE);
      ld   = MemtoRegE && RegWE && (WA3E == RA1D || WA3E == RA2D);
      chk("m_state",  mc_state,   st);
      chk("m_tmo",    mc_timeout, m_tmo);
      chk("m_fwdA",   ForwardAE,  exp_fwd(RA1E));
      chk("m_fwdB",   ForwardBE,  exp_fwd(RA2E));
      chk("m_stallF", StallF, busy ? 1'b1 : (ld && !PCSrcE));
      chk("m_stallD", StallD, busy ? 1'b1 : (ld && !PCSrcE));
      chk("m_stallE", StallE, busy);
      chk("m_flushD", FlushD, busy ? 1'b0 : PCSrcE);
      chk("m_flushE", FlushE, busy ? 1'b0 : (PCSrcE || ld));
      chk("m_flushM", FlushM, busy);
    end
  end

  task automatic clear_in();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWE, MemtoRegE, RegWM, RegWW, PCSrcE, MStartE, MDone} = '0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  initial begin
    int busy_cnt;
    clear_in();
    #12;
    // Reset state, checked while reset is still held.
    chk("rst_state", mc_state, 2'b00);
    chk("rst_tmo", mc_timeout, 1'b0);
    chk("rst_outs", {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE}, 10'h0);
    rst_n = 1'b1;
    step();
    cmp_en = 1;

    // 1. Forwarding priority and R15 exclusion.
    RegWM = 1; WA3M = 3; RA1E = 3; RegWW = 1; WA3W = 3;
    #2 chk("fwd_mem", ForwardAE, 2'b10);
    WA3M = 15;
    #1 chk("fwd_wb_r15", ForwardAE, 2'b01);
    RA2E = 3;
    #1 chk("fwd_b_wb", ForwardBE, 2'b01);
    step(); clear_in();

    // 2. Load-use stall for exactly one cycle.
    MemtoRegE = 1; RegWE = 1; WA3E = 5; RA2D = 5;
    #2 chk("ld_stall", {StallF, StallD, FlushE, FlushD, StallE}, 5'b11100);
    step(); clear_in();
    #2 chk("ld_after", {StallF, StallD, FlushE, FlushD}, 4'b0000);
    step();

    // 3. Branch wins over load-use.
    MemtoRegE = 1; RegWE = 1; WA3E = 7; RA1D = 7; PCSrcE = 1;
    #2 chk("br_ld", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    step(); clear_in();

    // 4. MC op from cycle 0 with MDone at cycle 6.
    for (int c = 0; c <= 8; c++) begin
      MStartE = (c == 0); MDone = (c == 6);
      #2;
      chk($sformatf("mc_stallE_c%0d", c), StallE, (c <= 6));
      if (c == 1) chk("mc_busy_c1", mc_state, 2'b01);
      if (c == 7) chk("mc_done_c7", mc_state, 2'b10);
      if (c == 8) chk("mc_idle_c8", mc_state, 2'b00);
      step();
    end
    clear_in();

    // 5. Watchdog: 40 busy cycles then DONE with sticky timeout.
    MStartE = 1;
    step();
    MStartE = 0;
    busy_cnt = 0;
    for (int c = 0; c < 100 && mc_state == 2'b01; c++) begin
      busy_cnt++;
      step();
    end
    chk("wd_busy_cycles", busy_cnt, MAXC);
    chk("wd_state_done", mc_state, 2'b10);
    chk("wd_tmo_set", mc_timeout, 1'b1);
    repeat (5) step();
    chk("wd_tmo_sticky", mc_timeout, 1'b1);

    // 6. Asynchronous reset mid-busy.
    MStartE = 1;
    step();
    MStartE = 0;
    step();
    chk("ar_busy", mc_state, 2'b01);
    #2 rst_n = 0;
    #1;
    chk("ar_state", mc_state, 2'b00);
    chk("ar_stalls", {StallF, StallD, StallE, FlushM}, 4'b0000);
    chk("ar_tmo", mc_timeout, 1'b0);
    #1 rst_n = 1;
    step();

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 4000; c++) begin
      RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
      WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      RegWE = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      RegWM = 1'($urandom_range(0, 1)); RegWW = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0);
      MStartE = ($urandom_range(0, 7) == 0);
      // Long quiet stretches on MDone so the watchdog also fires.
      MDone = ((c / 500) % 2 == 1) ? 1'b0 : ($urandom_range(0, 11) == 0);
      if (c % 700 == 350) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
      step();
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
